bcjr_max_log_engine: RTL and testbench

- Sequential, frame-buffered max-log BCJR (max-product) SISO decoder for one binary RSC constituent code.
- Computes per-bit extrinsic LLRs from systematic, parity and a-priori LLRs for one frame at a time.
- Successor to the fully parallel half-float max-product path. Adds parametrised code polynomials/memory, runtime frame length, trellis termination mode, saturating fixed-point metrics and valid/ready handshakes.
- Sits between turbo interleaver/deinterleaver stages.

---
 rtl/bcjr_max_log_engine.sv | 263 ++++++++++++++++++++++++++
 tb/tb_bcjr_max_log_engine.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bcjr_max_log_engine.sv
// Frame-buffered max-log BCJR SISO decoder for one binary RSC constituent code.
// Loads a frame, runs the forward recursion into alpha RAM, then emits extrinsic LLRs in reverse order.
module bcjr_max_log_engine #(
   parameter int BITS        = 8,
   parameter int METRIC_BITS = 12,
   parameter int MEMORY      = 2,
   parameter int FB_POLY     = 7,
   parameter int FF_POLY     = 5,
   parameter int MAX_FRAME   = 64,
   parameter int TERMINATED  = 1
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic [$clog2(MAX_FRAME+1)-1:0] frame_len,
   input  logic                           in_valid,
   output logic                           in_ready,
   input  logic signed [BITS-1:0]         in_sys,
   input  logic signed [BITS-1:0]         in_par,
   input  logic signed [BITS-1:0]         in_apri,
   output logic                           out_valid,
   input  logic                           out_ready,
   output logic signed [BITS-1:0]         out_llr,
   output logic [$clog2(MAX_FRAME)-1:0]   out_index,
   output logic                           out_last,
   output logic                           busy
);
   localparam int STATES = 1 << MEMORY;
   localparam int LW     = $clog2(MAX_FRAME+1);
   localparam int IW     = $clog2(MAX_FRAME);
   localparam int MW     = METRIC_BITS;
   localparam int M_NEG  = -(1 << (MW-1));
   localparam int M_POS  = (1 << (MW-1)) - 1;
   localparam int L_NEG  = -(1 << (BITS-1));
   localparam int L_POS  = (1 << (BITS-1)) - 1;

   typedef logic signed [MW-1:0]   metric_t;
   typedef logic signed [BITS-1:0] llr_t;
   typedef enum logic [1:0] {S_LOAD, S_FWD, S_BWD} state_t;

   localparam metric_t NEG = metric_t'(M_NEG);

   // Trellis: state bit j holds delay element MEMORY-j; feedback bit enters at the MSB.
   function automatic int trel_fb(input int s, input int u);
      int a;
      a = u;
      for (int j = 0; j < MEMORY; j++) a = a ^ ((FB_POLY >> j) & (s >> j) & 1);
      return a;
   endfunction

   function automatic int trel_next(input int s, input int u);
      return (trel_fb(s, u) << (MEMORY-1)) | (s >> 1);
   endfunction

   function automatic int trel_par(input int s, input int u);
      int p;
      p = (FF_POLY >> MEMORY) & trel_fb(s, u) & 1;
      for (int j = 0; j < MEMORY; j++) p = p ^ ((FF_POLY >> j) & (s >> j) & 1);
      return p;
   endfunction

   function automatic metric_t sat_metric(input int v);
      if (v > M_POS) return metric_t'(M_POS);
      if (v < M_NEG) return metric_t'(M_NEG);
      return metric_t'(v);
   endfunction

   // NEG behaves as -inf and absorbs any addend.
   function automatic metric_t madd(input metric_t a, input metric_t b);
      if (a == NEG || b == NEG) return NEG;
      return sat_metric(int'(a) + int'(b));
   endfunction

   function automatic metric_t mnorm(input metric_t x, input metric_t r0);
      if (x == NEG) return NEG;
      return sat_metric(int'(x) - int'(r0));
   endfunction

   function automatic metric_t mmax(input metric_t a, input metric_t b);
      return (a > b) ? a : b;
   endfunction

   function automatic llr_t sat_llr(input int v);
      if (v > L_POS) return llr_t'(L_POS);
      if (v < L_NEG) return llr_t'(L_NEG);
      return llr_t'(v);
   endfunction

   function automatic metric_t br_gamma(input int u, input int p, input metric_t sa, input metric_t lp);
      metric_t g;
      g = '0;
      if (u != 0) g = sa;
      if (p != 0) g = g + lp;
      return g;
   endfunction

   state_t               state_q, state_d;
   logic [IW-1:0]        cnt_q, cnt_d;
   logic [LW-1:0]        n_q, n_d, len_eff, n_cur;
   logic                 out_valid_q, out_valid_d, out_last_q, out_last_d;
   llr_t                 out_llr_q, out_llr_d, ext;
   logic [IW-1:0]        out_index_q, out_index_d;
   logic                 load_hs, fwd_step;

   metric_t              alpha_q [STATES], alpha_d [STATES], alpha_nx [STATES], alpha_norm [STATES];
   metric_t              beta_q [STATES], beta_d [STATES], beta_nx [STATES], beta_norm [STATES];
   metric_t              alpha_k [STATES], alpha_init [STATES], beta_init [STATES];
   metric_t              g_sa, g_p, llr_m0, llr_m1;
   logic [STATES*MW-1:0] alpha_wr, alpha_rd;

   logic [STATES*MW-1:0] alpha_ram [MAX_FRAME];
   llr_t                 sys_mem [MAX_FRAME];
   llr_t                 par_mem [MAX_FRAME];
   llr_t                 apri_mem [MAX_FRAME];

   assign g_sa     = sat_metric(int'(sys_mem[cnt_q]) + int'(apri_mem[cnt_q]));
   assign g_p      = sat_metric(int'(par_mem[cnt_q]));
   assign alpha_rd = alpha_ram[cnt_q];

   always_comb begin
      alpha_wr = '0;
      for (int s = 0; s < STATES; s++) begin
         alpha_wr[s*MW +: MW] = alpha_q[s];
         alpha_k[s]           = metric_t'(alpha_rd[s*MW +: MW]);
         alpha_init[s]        = (s == 0) ? metric_t'(0) : NEG;
         beta_init[s]         = (s == 0 || TERMINATED == 0) ? metric_t'(0) : NEG;
      end
   end

   // Shared trellis kernel: forward ACS, backward ACS and the two LLR maxima.
   always_comb begin
      llr_m0 = NEG;
      llr_m1 = NEG;
      for (int s = 0; s < STATES; s++) begin
         alpha_nx[s] = NEG;
         beta_nx[s]  = NEG;
      end
      for (int s = 0; s < STATES; s++) begin
         for (int u = 0; u < 2; u++) begin
            for (int sp = 0; sp < STATES; sp++) begin
               if (trel_next(s, u) == sp) begin
                  alpha_nx[sp] = mmax(alpha_nx[sp],
                                      madd(alpha_q[s], br_gamma(u, trel_par(s, u), g_sa, g_p)));
                  beta_nx[s]   = mmax(beta_nx[s],
                                      madd(br_gamma(u, trel_par(s, u), g_sa, g_p), beta_q[sp]));
                  if (u == 1)
                     llr_m1 = mmax(llr_m1, madd(madd(alpha_k[s],
                                   br_gamma(u, trel_par(s, u), g_sa, g_p)), beta_q[sp]));
                  else
                     llr_m0 = mmax(llr_m0, madd(madd(alpha_k[s],
                                   br_gamma(u, trel_par(s, u), g_sa, g_p)), beta_q[sp]));
               end
            end
         end
      end
      for (int s = 0; s < STATES; s++) begin
         alpha_norm[s] = mnorm(alpha_nx[s], alpha_nx[0]);
         beta_norm[s]  = mnorm(beta_nx[s], beta_nx[0]);
      end
   end

   assign ext = sat_llr(int'(llr_m1) - int'(llr_m0) - int'(sys_mem[cnt_q]) - int'(apri_mem[cnt_q]));

   assign len_eff = (frame_len == '0 || frame_len > LW'(MAX_FRAME)) ? LW'(MAX_FRAME) : frame_len;
   assign n_cur   = (cnt_q == '0) ? len_eff : n_q;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      n_d         = n_q;
      out_valid_d = out_valid_q;
      out_llr_d   = out_llr_q;
      out_index_d = out_index_q;
      out_last_d  = out_last_q;
      alpha_d     = alpha_q;
      beta_d      = beta_q;
      in_ready    = 1'b0;
      load_hs     = 1'b0;
      fwd_step    = 1'b0;
      case (state_q)
         S_LOAD: begin
            in_ready = 1'b1;
            if (in_valid) begin
               load_hs = 1'b1;
               if (cnt_q == '0) n_d = len_eff;
               if (LW'(cnt_q) == n_cur - LW'(1)) begin
                  state_d = S_FWD;
                  cnt_d   = '0;
                  alpha_d = alpha_init;
               end else begin
                  cnt_d = cnt_q + IW'(1);
               end
            end
         end
         S_FWD: begin
            fwd_step = 1'b1;
            alpha_d  = alpha_norm;
            if (LW'(cnt_q) == n_q - LW'(1)) begin
               state_d = S_BWD;
               beta_d  = beta_init;
            end else begin
               cnt_d = cnt_q + IW'(1);
            end
         end
         S_BWD: begin
            if (out_valid_q && out_ready) begin
               out_valid_d = 1'b0;
               if (out_last_q) begin
                  state_d = S_LOAD;
                  cnt_d   = '0;
               end
            end
            // A step only advances when the output register is free or being drained.
            if (!(out_valid_q && out_last_q) && (!out_valid_q || out_ready)) begin
               out_valid_d = 1'b1;
               out_llr_d   = ext;
               out_index_d = cnt_q;
               out_last_d  = (cnt_q == '0);
               beta_d      = beta_norm;
               if (cnt_q != '0) cnt_d = cnt_q - IW'(1);
            end
         end
         default: state_d = S_LOAD;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= S_LOAD;
         cnt_q       <= '0;
         n_q         <= '0;
         out_valid_q <= 1'b0;
         out_llr_q   <= '0;
         out_index_q <= '0;
         out_last_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         n_q         <= n_d;
         out_valid_q <= out_valid_d;
         out_llr_q   <= out_llr_d;
         out_index_q <= out_index_d;
         out_last_q  <= out_last_d;
      end
   end

   always_ff @(posedge clk) begin
      alpha_q <= alpha_d;
      beta_q  <= beta_d;
      if (load_hs) begin
         sys_mem[cnt_q]  <= in_sys;
         par_mem[cnt_q]  <= in_par;
         apri_mem[cnt_q] <= in_apri;
      end
      if (fwd_step) alpha_ram[cnt_q] <= alpha_wr;
   end

   assign out_valid = out_valid_q;
   assign out_llr   = out_llr_q;
   assign out_index = out_index_q;
   assign out_last  = out_last_q;
   assign busy      = (state_q != S_LOAD) || (cnt_q != '0);

endmodule

// File: tb/tb_bcjr_max_log_engine.sv
// Bench for bcjr_max_log_engine: table of frames plus reset-abort sequence, checked against a
// max-log BCJR reference computed directly from the encoder definition.
module tb_bcjr_max_log_engine;
   localparam int BITS = 8;
   localparam int MB   = 12;
   localparam int MEM  = 2;
   localparam int FBP  = 7;
   localparam int FFP  = 5;
   localparam int MAXF = 64;
   localparam int TERM = 1;
   localparam int NS   = 1 << MEM;
   localparam int LW   = $clog2(MAXF+1);
   localparam int IW   = $clog2(MAXF);
   localparam int NEGM = -(1 << (MB-1));
   localparam int POSM = (1 << (MB-1)) - 1;

   logic                   clk = 1'b0;
   logic                   reset;
   logic [LW-1:0]          frame_len;
   logic                   in_valid, in_ready, out_valid, out_ready, out_last, busy;
   logic signed [BITS-1:0] in_sys, in_par, in_apri, out_llr;
   logic [IW-1:0]          out_index;

   always #5 clk = ~clk;

   bcjr_max_log_engine #(
      .BITS(BITS), .METRIC_BITS(MB), .MEMORY(MEM), .FB_POLY(FBP), .FF_POLY(FFP),
      .MAX_FRAME(MAXF), .TERMINATED(TERM)
   ) dut (
      .clk(clk), .reset(reset), .frame_len(frame_len), .in_valid(in_valid), .in_ready(in_ready),
      .in_sys(in_sys), .in_par(in_par), .in_apri(in_apri), .out_valid(out_valid),
      .out_ready(out_ready), .out_llr(out_llr), .out_index(out_index), .out_last(out_last),
      .busy(busy)
   );

   typedef struct {
      int len_field;
      int n;
      int mode;      // 0 constant, 1 full-range random, 2 reuse previous frame, 3 small random
      int sys;
      int par;
      int apri;
      bit stall;
      bit gaps;
      int sign_req;  // 0 none, -1 every output negative, 2 every output zero
   } vec_t;

   vec_t tbl [9];
   int   n_cmp = 0;
   int   n_bad = 0;
   int   f_sys [MAXF];
   int   f_par [MAXF];
   int   f_apri [MAXF];
   int   exp_llr [MAXF];
   int   alpha_m [MAXF+1][NS];

   task automatic check(input string name, input int act, input int req);
      n_cmp++;
      if (act != req) begin
         n_bad++;
         $display("FAIL %s: got %0d, required %0d", name, act, req);
      end
   endtask

   function automatic int clampi(input int v, input int lo, input int hi);
      return (v > hi) ? hi : ((v < lo) ? lo : v);
   endfunction

   function automatic int m_add(input int a, input int b);
      if (a == NEGM || b == NEGM) return NEGM;
      return clampi(a + b, NEGM, POSM);
   endfunction

   function automatic int m_norm(input int x, input int r0);
      if (x == NEGM) return NEGM;
      return clampi(x - r0, NEGM, POSM);
   endfunction

   // Encoder as a shift register: d[0] is the feedback sum, d[1..MEM] the delay line.
   function automatic void encode(input int s, input int u, output int ns, output int p);
      int d [MEM+1];
      for (int j = 1; j <= MEM; j++) d[j] = (s >> (MEM-j)) & 1;
      d[0] = u;
      for (int j = 1; j <= MEM; j++) if (((FBP >> (MEM-j)) & 1) != 0) d[0] = d[0] ^ d[j];
      p = 0;
      for (int j = 0; j <= MEM; j++) if (((FFP >> (MEM-j)) & 1) != 0) p = p ^ d[j];
      ns = 0;
      for (int j = 0; j < MEM; j++) ns = (ns << 1) | d[j];
   endfunction

   function automatic int gain(input int k, input int u, input int p);
      return (u != 0 ? f_sys[k] + f_apri[k] : 0) + (p != 0 ? f_par[k] : 0);
   endfunction

   function automatic void run_model(input int n);
      int nxt [NS];
      int beta [NS];
      int ns, p, g, m0, m1;
      for (int s = 0; s < NS; s++) alpha_m[0][s] = (s == 0) ? 0 : NEGM;
      for (int k = 0; k < n; k++) begin
         for (int s = 0; s < NS; s++) nxt[s] = NEGM;
         for (int s = 0; s < NS; s++)
            for (int u = 0; u < 2; u++) begin
               encode(s, u, ns, p);
               g = m_add(alpha_m[k][s], gain(k, u, p));
               if (g > nxt[ns]) nxt[ns] = g;
            end
         for (int s = 0; s < NS; s++) alpha_m[k+1][s] = m_norm(nxt[s], nxt[0]);
      end
      for (int s = 0; s < NS; s++) beta[s] = (s == 0 || TERM == 0) ? 0 : NEGM;
      for (int k = n - 1; k >= 0; k--) begin
         m0 = NEGM;
         m1 = NEGM;
         for (int s = 0; s < NS; s++) nxt[s] = NEGM;
         for (int s = 0; s < NS; s++)
            for (int u = 0; u < 2; u++) begin
               encode(s, u, ns, p);
               g = m_add(m_add(alpha_m[k][s], gain(k, u, p)), beta[ns]);
               if (u == 1 && g > m1) m1 = g;
               if (u == 0 && g > m0) m0 = g;
               g = m_add(gain(k, u, p), beta[ns]);
               if (g > nxt[s]) nxt[s] = g;
            end
         exp_llr[k] = clampi(m1 - m0 - f_sys[k] - f_apri[k], -(1 << (BITS-1)), (1 << (BITS-1)) - 1);
         for (int s = 0; s < NS; s++) beta[s] = m_norm(nxt[s], nxt[0]);
      end
   endfunction

   task automatic load_frame(input int len_field, input int n, input bit gaps);
      int i = 0;
      int cyc = 0;
      while (i < n && cyc < 8 * MAXF) begin
         @(negedge clk);
         cyc++;
         frame_len = LW'(len_field);
         in_valid  = (gaps == 1'b0) || ($urandom_range(0, 3) != 0);
         if (in_valid) begin
            in_sys  = BITS'(f_sys[i]);
            in_par  = BITS'(f_par[i]);
            in_apri = BITS'(f_apri[i]);
         end else begin
            in_sys  = BITS'($urandom);
            in_par  = BITS'($urandom);
            in_apri = BITS'($urandom);
         end
         if (in_valid && in_ready) i++;
      end
      check("load_timeout", i, n);
      @(negedge clk);
      in_valid = 1'b0;
      in_sys   = BITS'($urandom);
      check("in_ready_after_load", int'(in_ready), 0);
      check("busy_after_load", int'(busy), 1);
   endtask

   task automatic collect(input int n, input bit stall, input int sign_req);
      int got = 0;
      int cyc = 0;
      bit prev_stall = 1'b0;
      int prev_llr = 0;
      int prev_idx = 0;
      while (got < n && cyc < 20 * MAXF + 100) begin
         @(negedge clk);
         cyc++;
         if (prev_stall) begin
            check("hold_valid", int'(out_valid), 1);
            check("hold_llr", int'(out_llr), prev_llr);
            check("hold_index", int'(out_index), prev_idx);
         end
         out_ready  = stall ? 1'($urandom_range(0, 1)) : 1'b1;
         prev_stall = 1'b0;
         if (out_valid) begin
            if (out_ready) begin
               check("out_index", int'(out_index), n - 1 - got);
               check("out_llr", int'(out_llr), exp_llr[n - 1 - got]);
               check("out_last", int'(out_last), (got == n - 1) ? 1 : 0);
               if (sign_req == -1) check("llr_negative", (int'(out_llr) < 0) ? 1 : 0, 1);
               if (sign_req == 2) check("llr_zero", int'(out_llr), 0);
               got++;
            end else begin
               prev_stall = 1'b1;
               prev_llr   = int'(out_llr);
               prev_idx   = int'(out_index);
            end
         end
      end
      check("output_count", got, n);
      @(negedge clk);
      out_ready = 1'b1;
      check("in_ready_after_last", int'(in_ready), 1);
      check("out_valid_after_last", int'(out_valid), 0);
   endtask

   task automatic fill(input vec_t v);
      for (int k = 0; k < v.n; k++) begin
         case (v.mode)
            0: begin f_sys[k] = v.sys; f_par[k] = v.par; f_apri[k] = v.apri; end
            1: begin
               f_sys[k]  = $urandom_range(0, 255) - 128;
               f_par[k]  = $urandom_range(0, 255) - 128;
               f_apri[k] = $urandom_range(0, 255) - 128;
            end
            3: begin
               f_sys[k]  = $urandom_range(0, 80) - 40;
               f_par[k]  = $urandom_range(0, 80) - 40;
               f_apri[k] = $urandom_range(0, 30) - 15;
            end
            default: ;
         endcase
      end
   endtask

   task automatic check_idle(input string tag);
      check({tag, "_in_ready"}, int'(in_ready), 1);
      check({tag, "_out_valid"}, int'(out_valid), 0);
      check({tag, "_busy"}, int'(busy), 0);
      check({tag, "_out_llr"}, int'(out_llr), 0);
      check({tag, "_out_index"}, int'(out_index), 0);
      check({tag, "_out_last"}, int'(out_last), 0);
   endtask

   initial begin
      reset     = 1'b1;
      in_valid  = 1'b0;
      in_sys    = '0;
      in_par    = '0;
      in_apri   = '0;
      out_ready = 1'b1;
      frame_len = '0;
      repeat (3) @(negedge clk);
      check_idle("reset");
      reset = 1'b0;

      tbl[0] = '{8,   8,  0,   0,   0,   0, 1'b0, 1'b0,  2};
      tbl[1] = '{8,   8,  0, -20, -20,   0, 1'b0, 1'b0, -1};
      tbl[2] = '{8,   8,  0, 127, 127, 127, 1'b0, 1'b0,  0};
      tbl[3] = '{1,   1,  0,  30, -10,   5, 1'b0, 1'b0,  0};
      tbl[4] = '{0,   64, 3,   0,   0,   0, 1'b0, 1'b1,  0};
      tbl[5] = '{12,  12, 3,   0,   0,   0, 1'b0, 1'b0,  0};
      tbl[6] = '{12,  12, 2,   0,   0,   0, 1'b1, 1'b0,  0};
      tbl[7] = '{100, 64, 1,   0,   0,   0, 1'b1, 1'b1,  0};
      tbl[8] = '{5,   5,  3,   0,   0,   0, 1'b1, 1'b1,  0};

      for (int t = 0; t < 9; t++) begin
         fill(tbl[t]);
         run_model(tbl[t].n);
         load_frame(tbl[t].len_field, tbl[t].n, tbl[t].gaps);
         collect(tbl[t].n, tbl[t].stall, tbl[t].sign_req);
      end

      // Abort a frame three cycles into the forward pass, then decode a fresh frame.
      fill('{16, 16, 1, 0, 0, 0, 1'b0, 1'b0, 0});
      load_frame(16, 16, 1'b0);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check_idle("abort");
      reset = 1'b0;
      fill('{10, 10, 3, 0, 0, 0, 1'b0, 1'b0, 0});
      run_model(10);
      load_frame(10, 10, 1'b1);
      collect(10, 1'b1, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
